// File: rtl/sta_pkg.sv
// Shared types, fail codes and graph constants for the STA timing-graph self-test driver.
// Node ranks define the topological order the generated DAG must respect.
package sta_pkg;

    localparam int N_NODE = 16;
    localparam int N_EDGE = 32;

    // Fibonacci taps 16,14,13,11 as a bit mask over state[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GEN  = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_RECV = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam logic [2:0] FC_OK    = 3'd0;
    localparam logic [2:0] FC_TMO   = 3'd1;
    localparam logic [2:0] FC_FIRST = 3'd2;
    localparam logic [2:0] FC_LAST  = 3'd3;
    localparam logic [2:0] FC_HOP   = 3'd4;
    localparam logic [2:0] FC_SUM   = 3'd5;
    localparam logic [2:0] FC_LONG  = 3'd6;
    localparam logic [2:0] FC_WD    = 3'd7;

    // Source ranks first, sink ranks last, everything else keeps its order
    function automatic logic [3:0] rank(input logic [3:0] n);
        if (n == 4'd0)
            rank = 4'd0;
        else if (n == 4'd1)
            rank = 4'd15;
        else
            rank = n - 4'd1;
    endfunction

endpackage

// File: rtl/sta_lfsr16.sv
// 16-bit Fibonacci LFSR; load has priority over enable, state updates one cycle later.
// No flow control: the owner decides when to step via en_i.
module sta_lfsr16
    import sta_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = seed_i;
        else if (en_i)
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= 16'h0000;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/sta_graph_driver.sv
// Self-test master for the STA core: builds a random 16-node DAG, streams it, then checks the path reply.
// Stream is fixed-length with no backpressure; the reply is consumed one node per out_valid cycle.
module sta_graph_driver
    import sta_pkg::*;
#(
    parameter int          TIMEOUT  = 1024,
    parameter logic [15:0] SEED_DEF = 16'hACE1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        in_valid,
    output logic [3:0]  delay,
    output logic [3:0]  source,
    output logic [3:0]  destination,
    input  logic        out_valid,
    input  logic [7:0]  worst_delay,
    input  logic [3:0]  path,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_code,
    output logic [7:0]  rpt_delay,
    output logic [4:0]  rpt_len
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [5:0]      ecnt_q, ecnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [4:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      rptd_q, rptd_d;
    logic [3:0]      prev_q, prev_d;
    logic [2:0]      fail_q, fail_d;
    logic            pass_q, pass_d;
    logic [2:0]      code, node_code, end_code;

    logic [7:0]                 edge_q [N_EDGE];
    logic [3:0]                 dly_q  [N_NODE];
    logic [N_NODE*N_NODE-1:0]   used_q;

    logic [15:0] lfsr;
    logic [3:0]  lfsr_unused;
    logic        start_go, gen_acc, node_vld, first;
    logic [3:0]  cand_a, cand_b, cand_src, cand_dst;

    assign start_go    = (state_q == ST_IDLE) && start;
    assign lfsr_unused = lfsr[15:12];

    sta_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_go),
        .en_i    ((state_q == ST_GEN) || (state_q == ST_SEND)),
        .seed_i  ((seed == 16'd0) ? SEED_DEF : seed),
        .state_o (lfsr)
    );

    // Candidate edge, oriented so it always points forward in rank order
    always_comb begin
        cand_a = lfsr[3:0];
        cand_b = lfsr[7:4];
        if (rank(cand_a) < rank(cand_b)) begin
            cand_src = cand_a;
            cand_dst = cand_b;
        end else begin
            cand_src = cand_b;
            cand_dst = cand_a;
        end
        gen_acc = (state_q == ST_GEN) && (rank(cand_a) != rank(cand_b))
                  && !used_q[{cand_src, cand_dst}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
            for (int i = 0; i < N_EDGE; i++) edge_q[i] <= 8'h00;
            for (int i = 0; i < N_NODE; i++) dly_q[i] <= 4'h0;
        end else begin
            if (start_go) begin
                used_q        <= '0;
                used_q[8'h01] <= 1'b1;
                edge_q[0]     <= 8'h01;
            end else if (gen_acc) begin
                used_q[{cand_src, cand_dst}] <= 1'b1;
                edge_q[ecnt_q[4:0]]          <= {cand_src, cand_dst};
            end
            if (in_valid && (ecnt_q < 6'(N_NODE)))
                dly_q[ecnt_q[3:0]] <= lfsr[11:8];
        end
    end

    assign node_vld = ((state_q == ST_WAIT) || (state_q == ST_RECV)) && out_valid;
    assign first    = (len_q == 5'd0);

    // Lowest code wins when several checks trip on the same node
    always_comb begin
        node_code = FC_OK;
        if (first) begin
            if (path != 4'd0) node_code = FC_FIRST;
        end else if (!used_q[{prev_q, path}]) begin
            node_code = FC_HOP;
        end else if (len_q >= 5'd16) begin
            node_code = FC_LONG;
        end else if (worst_delay != 8'd0) begin
            node_code = FC_WD;
        end
        if (prev_q != 4'd1)
            end_code = FC_LAST;
        else if (sum_q != rptd_q)
            end_code = FC_SUM;
        else
            end_code = FC_OK;
    end

    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        tmo_d   = tmo_q;
        len_d   = len_q;
        sum_d   = sum_q;
        prev_d  = prev_q;
        rptd_d  = rptd_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        code    = FC_OK;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_GEN;
                ecnt_d  = 6'd1;
                len_d   = 5'd0;
                sum_d   = 8'd0;
                prev_d  = 4'd0;
                rptd_d  = 8'd0;
                fail_d  = FC_OK;
                pass_d  = 1'b0;
            end
            ST_GEN: if (gen_acc) begin
                ecnt_d = ecnt_q + 6'd1;
                if (ecnt_q == 6'(N_EDGE - 1)) begin
                    state_d = ST_SEND;
                    ecnt_d  = 6'd0;
                end
            end
            ST_SEND: begin
                ecnt_d = ecnt_q + 6'd1;
                if (ecnt_q == 6'(N_EDGE - 1)) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                if (out_valid) begin
                    state_d = ST_RECV;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    code    = FC_TMO;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RECV: if (!out_valid) begin
                code    = end_code;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (node_vld) begin
            code   = node_code;
            len_d  = (len_q == 5'd31) ? len_q : len_q + 5'd1;
            sum_d  = sum_q + {4'd0, dly_q[path]};
            prev_d = path;
            if (first) rptd_d = worst_delay;
        end
        if (fail_q == FC_OK && state_q != ST_IDLE)
            fail_d = code;
        if (state_d == ST_DONE)
            pass_d = (fail_d == FC_OK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ecnt_q  <= 6'd0;
            tmo_q   <= '0;
            len_q   <= 5'd0;
            sum_q   <= 8'd0;
            rptd_q  <= 8'd0;
            prev_q  <= 4'd0;
            fail_q  <= FC_OK;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            rptd_q  <= rptd_d;
            prev_q  <= prev_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign in_valid    = (state_q == ST_SEND);
    assign source      = in_valid ? edge_q[ecnt_q[4:0]][7:4] : 4'd0;
    assign destination = in_valid ? edge_q[ecnt_q[4:0]][3:0] : 4'd0;
    assign delay       = (in_valid && (ecnt_q < 6'(N_NODE))) ? lfsr[11:8] : 4'd0;
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign fail_code   = fail_q;
    assign rpt_delay   = rptd_q;
    assign rpt_len     = len_q;

endmodule

// File: tb/tb_sta_graph_driver.sv
// Directed self-checking bench for sta_graph_driver: stream legality, reply checking, timeout, reset, start filtering.
module tb_sta_graph_driver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic        busy, in_valid, done, pass;
    logic [3:0]  delay, source, destination, path;
    logic        out_valid;
    logic [7:0]  worst_delay, rpt_delay;
    logic [2:0]  fail_code;
    logic [4:0]  rpt_len;

    int n_chk  = 0;
    int n_fail = 0;

    int cap_src [32];
    int cap_dst [32];
    int cap_dly [32];
    int cap_n;
    int ref_src [32];
    int ref_dst [32];
    int ref_dly [32];

    sta_graph_driver #(.TIMEOUT(1024), .SEED_DEF(16'hACE1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .seed        (seed),
        .busy        (busy),
        .in_valid    (in_valid),
        .delay       (delay),
        .source      (source),
        .destination (destination),
        .out_valid   (out_valid),
        .worst_delay (worst_delay),
        .path        (path),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .rpt_delay   (rpt_delay),
        .rpt_len     (rpt_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int trank(input int n);
        if (n == 0) return 0;
        if (n == 1) return 15;
        return n - 1;
    endfunction

    function automatic bit has_edge(input int s, input int d);
        for (int i = 0; i < 32; i++)
            if (cap_src[i] == s && cap_dst[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int stream_diff();
        int m = 0;
        for (int i = 0; i < 32; i++)
            if (cap_src[i] != ref_src[i] || cap_dst[i] != ref_dst[i] || cap_dly[i] != ref_dly[i]) m++;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] s);
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
    endtask

    task automatic capture_send();
        int k = 0;
        for (int i = 0; i < 32; i++) begin
            cap_src[i] = -1; cap_dst[i] = -1; cap_dly[i] = -1;
        end
        while (!in_valid && k < 4000) begin
            tick();
            k++;
        end
        cap_n = 0;
        while (in_valid && cap_n < 40) begin
            if (cap_n < 32) begin
                cap_src[cap_n] = int'(source);
                cap_dst[cap_n] = int'(destination);
                cap_dly[cap_n] = int'(delay);
            end
            cap_n++;
            tick();
        end
    endtask

    task automatic save_ref();
        for (int i = 0; i < 32; i++) begin
            ref_src[i] = cap_src[i]; ref_dst[i] = cap_dst[i]; ref_dly[i] = cap_dly[i];
        end
    endtask

    // Drives up to three path nodes, then waits (bounded) for done
    task automatic send_resp(input int p0, input int p1, input int p2, input int len, input int wd,
                             output int wait_cyc);
        for (int i = 0; i < len; i++) begin
            out_valid   = 1'b1;
            path        = (i == 0) ? 4'(p0) : (i == 1) ? 4'(p1) : 4'(p2);
            worst_delay = (i == 0) ? 8'(wd) : 8'd0;
            tick();
        end
        out_valid   = 1'b0;
        path        = 4'd0;
        worst_delay = 8'd0;
        wait_cyc    = 0;
        while (!done && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_chk++;
        if ({busy, in_valid, done, pass, fail_code, rpt_delay, rpt_len, delay, source, destination} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b in_valid=%0b done=%0b pass=%0b code=%0d rdly=%0d rlen=%0d expected all 0",
                     busy, in_valid, done, pass, fail_code, rpt_delay, rpt_len);
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_sequence();
        int dup = 0, bad_rank = 0, dst0 = 0, tail = 0;
        do_start(16'h0001);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %0b expected 1", busy);
        end
        capture_send();
        n_chk++;
        if (cap_n != 32) begin
            n_fail++;
            $display("FAIL send_length: got %0d cycles expected 32", cap_n);
        end
        n_chk++;
        if (cap_src[0] != 0 || cap_dst[0] != 1) begin
            n_fail++;
            $display("FAIL edge0: got %0d->%0d expected 0->1", cap_src[0], cap_dst[0]);
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = i + 1; j < 32; j++)
                if (cap_src[i] == cap_src[j] && cap_dst[i] == cap_dst[j]) dup++;
            if (trank(cap_src[i]) >= trank(cap_dst[i])) bad_rank++;
            if (cap_dst[i] == 0) dst0++;
            if (i >= 16 && cap_dly[i] != 0) tail++;
        end
        n_chk++;
        if (dup != 0 || bad_rank != 0 || dst0 != 0) begin
            n_fail++;
            $display("FAIL dag_legal: got dup=%0d bad_rank=%0d dst0=%0d expected 0,0,0", dup, bad_rank, dst0);
        end
        n_chk++;
        if (tail != 0) begin
            n_fail++;
            $display("FAIL delay_tail: got %0d nonzero delays after cycle 15 expected 0", tail);
        end
        save_ref();
    endtask

    task automatic test_pass();
        int k = -1, len, wd, w;
        for (int n = 2; n < 16; n++)
            if (k < 0 && has_edge(0, n) && has_edge(n, 1)) k = n;
        if (k >= 0) begin
            len = 3; wd = cap_dly[0] + cap_dly[k] + cap_dly[1];
            send_resp(0, k, 1, 3, wd, w);
        end else begin
            len = 2; wd = cap_dly[0] + cap_dly[1];
            send_resp(0, 1, 0, 2, wd, w);
        end
        n_chk++;
        if (done !== 1'b1 || w != 1) begin
            n_fail++;
            $display("FAIL pass_done: got done=%0b after %0d cycles expected done=1 after 1", done, w);
        end
        n_chk++;
        if (pass !== 1'b1 || fail_code !== 3'd0) begin
            n_fail++;
            $display("FAIL pass_result: got pass=%0b code=%0d expected pass=1 code=0", pass, fail_code);
        end
        n_chk++;
        if (rpt_len !== 5'(len) || rpt_delay !== 8'(wd)) begin
            n_fail++;
            $display("FAIL pass_report: got len=%0d delay=%0d expected len=%0d delay=%0d", rpt_len, rpt_delay, len, wd);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%0b busy=%0b pass=%0b expected 0,0,1", done, busy, pass);
        end
    endtask

    task automatic test_delay_mismatch();
        int wd, w;
        do_start(16'h0001);
        capture_send();
        wd = cap_dly[0] + cap_dly[1] + 1;
        send_resp(0, 1, 0, 2, wd, w);
        n_chk++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 3'd5) begin
            n_fail++;
            $display("FAIL delay_mismatch: got done=%0b pass=%0b code=%0d expected 1,0,5", done, pass, fail_code);
        end
        tick();
    endtask

    task automatic test_illegal_hop();
        int k = 2, wd, w;
        bit found = 1'b0;
        do_start(16'h0001);
        capture_send();
        for (int n = 2; n < 16; n++)
            if (!found && !has_edge(0, n)) begin
                k = n;
                found = 1'b1;
            end
        wd = cap_dly[0] + cap_dly[k] + cap_dly[1];
        send_resp(0, k, 1, 3, wd, w);
        n_chk++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 3'd4 || rpt_len !== 5'd3) begin
            n_fail++;
            $display("FAIL illegal_hop: got done=%0b pass=%0b code=%0d len=%0d expected 1,0,4,3",
                     done, pass, fail_code, rpt_len);
        end
        tick();
    endtask

    task automatic test_timeout_seed();
        int c = 0;
        do_start(16'h0000);
        capture_send();
        save_ref();
        while (!done && c < 1100) begin
            tick();
            c++;
        end
        n_chk++;
        if (c != 1024) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d expected 1024", c);
        end
        n_chk++;
        if (fail_code !== 3'd1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_code: got code=%0d pass=%0b expected 1,0", fail_code, pass);
        end
        tick();
        do_start(16'hACE1);
        capture_send();
        n_chk++;
        if (cap_n != 32 || stream_diff() != 0) begin
            n_fail++;
            $display("FAIL seed_subst: got %0d differing cycles len=%0d expected 0 and 32", stream_diff(), cap_n);
        end
        c = 0;
        while (!done && c < 1100) begin
            tick();
            c++;
        end
        tick();
    endtask

    task automatic test_start_filter();
        int k = 0;
        do_start(16'h0001);
        start = 1'b1;
        seed  = 16'h5555;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cap_src[i] = -1; cap_dst[i] = -1; cap_dly[i] = -1;
        end
        while (!in_valid && k < 4000) begin
            tick();
            k++;
        end
        cap_n = 0;
        while (in_valid && cap_n < 40) begin
            if (cap_n < 32) begin
                cap_src[cap_n] = int'(source);
                cap_dst[cap_n] = int'(destination);
                cap_dly[cap_n] = int'(delay);
            end
            start = (cap_n == 5);
            seed  = 16'h1234;
            cap_n++;
            tick();
        end
        start = 1'b0;
        // seed-1 reference was overwritten by the seed-0 run; recompute it without interference
        n_chk++;
        if (cap_n != 32 || cap_src[0] != 0 || cap_dst[0] != 1) begin
            n_fail++;
            $display("FAIL start_filter_len: got len=%0d edge0=%0d->%0d expected 32 and 0->1",
                     cap_n, cap_src[0], cap_dst[0]);
        end
        save_ref();
    endtask

    task automatic test_reset_mid_send();
        int k = 0;
        do_start(16'h0001);
        while (!in_valid && k < 4000) begin
            tick();
            k++;
        end
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (in_valid !== 1'b0 || busy !== 1'b0 || source !== 4'd0 || destination !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got in_valid=%0b busy=%0b src=%0d dst=%0d expected all 0",
                     in_valid, busy, source, destination);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(16'h0001);
        capture_send();
        n_chk++;
        if (cap_n != 32 || stream_diff() != 0) begin
            n_fail++;
            $display("FAIL restart_stream: got len=%0d diff=%0d expected 32 and 0 vs undisturbed seed-1 run",
                     cap_n, stream_diff());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        seed        = 16'h0000;
        out_valid   = 1'b0;
        worst_delay = 8'd0;
        path        = 4'd0;
        test_reset();
        test_sequence();
        test_pass();
        test_delay_mismatch();
        test_illegal_hop();
        test_timeout_seed();
        test_start_filter();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
